// File: rtl/hs32_mem_arbiter_if.sv
// Bus bundle between the fetch/execute masters, the arbiter and the external HS32 memory port.
// The arbiter uses the slave view; the environment (masters + memory) uses the master view.
interface hs32_mem_arbiter_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_rdy;
  logic        e_req;
  logic [31:0] e_addr;
  logic [31:0] e_dtw;
  logic        e_rw;
  logic        e_rdy;
  logic [31:0] dtr;
  logic        err;
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_dtw;
  logic        m_rw;
  logic        m_rdy;
  logic [31:0] m_dtr;
  logic [1:0]  grant;

  modport slave (
    input  f_req, f_addr, e_req, e_addr, e_dtw, e_rw, m_rdy, m_dtr,
    output f_rdy, e_rdy, dtr, err, m_req, m_addr, m_dtw, m_rw, grant
  );

  modport master (
    output f_req, f_addr, e_req, e_addr, e_dtw, e_rw, m_rdy, m_dtr,
    input  f_rdy, e_rdy, dtr, err, m_req, m_addr, m_dtw, m_rw, grant
  );
endinterface

// File: rtl/hs32_mem_arbiter.sv
// Two-master arbiter for the HS32 memory bus: fetch (read-only) and execute (read/write),
// fixed or round-robin priority, with an optional watchdog that aborts unacknowledged accesses.
module hs32_mem_arbiter #(
  parameter bit          RR      = 1'b0,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned TW      = 8
) (
  input  logic               clk,
  input  logic               reset,
  hs32_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam bit            WD_EN    = (TIMEOUT != 0);
  localparam logic [TW-1:0] CNT_LAST = WD_EN ? TW'(TIMEOUT - 1) : '0;

  state_t        state_reg, state_next;
  logic          m_req_reg, m_req_next;
  logic [31:0]   m_addr_reg, m_addr_next;
  logic [31:0]   m_dtw_reg, m_dtw_next;
  logic          m_rw_reg, m_rw_next;
  logic [1:0]    grant_reg, grant_next;
  logic          last_reg, last_next;   // 1 = execute was served last
  logic [TW-1:0] cnt_reg, cnt_next;

  logic          exec_win;
  logic          f_rdy_c, e_rdy_c, err_c;
  logic [31:0]   dtr_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      m_req_reg  <= 1'b0;
      m_addr_reg <= '0;
      m_dtw_reg  <= '0;
      m_rw_reg   <= 1'b0;
      grant_reg  <= 2'b00;
      last_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      m_req_reg  <= m_req_next;
      m_addr_reg <= m_addr_next;
      m_dtw_reg  <= m_dtw_next;
      m_rw_reg   <= m_rw_next;
      grant_reg  <= grant_next;
      last_reg   <= last_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    m_req_next  = m_req_reg;
    m_addr_next = m_addr_reg;
    m_dtw_next  = m_dtw_reg;
    m_rw_next   = m_rw_reg;
    grant_next  = grant_reg;
    last_next   = last_reg;
    cnt_next    = cnt_reg;
    exec_win    = 1'b0;
    f_rdy_c     = 1'b0;
    e_rdy_c     = 1'b0;
    err_c       = 1'b0;
    dtr_c       = '0;

    case (state_reg)
      IDLE: begin
        if (bus.f_req || bus.e_req) begin
          // On a tie in round-robin mode the master that was not served last wins.
          if (RR) exec_win = bus.e_req && !(bus.f_req && last_reg);
          else    exec_win = bus.e_req;
          if (exec_win) begin
            m_addr_next = bus.e_addr;
            m_dtw_next  = bus.e_dtw;
            m_rw_next   = bus.e_rw;
            grant_next  = 2'b10;
          end else begin
            m_addr_next = bus.f_addr;
            m_dtw_next  = '0;
            m_rw_next   = 1'b0;
            grant_next  = 2'b01;
          end
          m_req_next = 1'b1;
          cnt_next   = '0;
          state_next = BUSY;
        end
      end

      BUSY: begin
        if (bus.m_rdy) begin
          f_rdy_c    = grant_reg[0];
          e_rdy_c    = grant_reg[1];
          dtr_c      = bus.m_dtr;
          m_req_next = 1'b0;
          last_next  = grant_reg[1];
          state_next = DONE;
        end else if (WD_EN && (cnt_reg == CNT_LAST)) begin
          // Abort: the master still sees a completion, flagged by err, with zero data.
          f_rdy_c    = grant_reg[0];
          e_rdy_c    = grant_reg[1];
          err_c      = 1'b1;
          m_req_next = 1'b0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + TW'(1);
        end
      end

      DONE: begin
        grant_next = 2'b00;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.m_req  = m_req_reg;
  assign bus.m_addr = m_addr_reg;
  assign bus.m_dtw  = m_dtw_reg;
  assign bus.m_rw   = m_rw_reg;
  assign bus.grant  = grant_reg;
  assign bus.f_rdy  = f_rdy_c;
  assign bus.e_rdy  = e_rdy_c;
  assign bus.err    = err_c;
  assign bus.dtr    = dtr_c;

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Bench for hs32_mem_arbiter: one instance per priority mode (index 0 = fixed, 1 = round-robin),
// both with a 4-cycle watchdog, driven by directed steps followed by randomized transactions.
module tb_hs32_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [1:0]       f_req, e_req, e_rw, m_rdy;
  logic [1:0][31:0] f_addr, e_addr, e_dtw, m_dtr;
  wire  [1:0]       f_rdy, e_rdy, err, m_req, m_rw;
  wire  [1:0][31:0] dtr, m_addr, m_dtw;
  wire  [1:0][1:0]  grant;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: which master was last served normally (1 = execute).
  bit last_m [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g
    hs32_mem_arbiter_if bus ();

    assign bus.f_req  = f_req[gi];
    assign bus.f_addr = f_addr[gi];
    assign bus.e_req  = e_req[gi];
    assign bus.e_addr = e_addr[gi];
    assign bus.e_dtw  = e_dtw[gi];
    assign bus.e_rw   = e_rw[gi];
    assign bus.m_rdy  = m_rdy[gi];
    assign bus.m_dtr  = m_dtr[gi];

    assign f_rdy[gi]  = bus.f_rdy;
    assign e_rdy[gi]  = bus.e_rdy;
    assign err[gi]    = bus.err;
    assign dtr[gi]    = bus.dtr;
    assign m_req[gi]  = bus.m_req;
    assign m_addr[gi] = bus.m_addr;
    assign m_dtw[gi]  = bus.m_dtw;
    assign m_rw[gi]   = bus.m_rw;
    assign grant[gi]  = bus.grant;

    hs32_mem_arbiter #(.RR(gi), .TIMEOUT(4), .TW(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction starting in an IDLE cycle with requests already applied.
  task automatic serve(input int u, input int wt, input bit ack, input bit hold,
                       input bit early_drop, input bit spur, input logic [31:0] rd);
    bit          ew;
    logic [31:0] xa, xd;
    bit          xrw;
    logic [1:0]  xg;
    bit          timed_out;
    if (u == 0) ew = e_req[u];
    else        ew = e_req[u] && !(f_req[u] && last_m[u]);
    xa  = ew ? e_addr[u] : f_addr[u];
    xd  = ew ? e_dtw[u] : 32'h0;
    xrw = ew ? e_rw[u] : 1'b0;
    xg  = ew ? 2'b10 : 2'b01;
    timed_out = 1'b0;

    tick();
    chk("grant", grant[u], xg);
    if (early_drop) begin
      if (ew) e_req[u] = 1'b0;
      else    f_req[u] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      chk("m_req_busy", m_req[u], 1);
      chk("m_addr", m_addr[u], xa);
      chk("m_dtw", m_dtw[u], xd);
      chk("m_rw", m_rw[u], xrw);
      if (ack && k == wt) begin
        m_rdy[u] = 1'b1;
        m_dtr[u] = rd;
        #1;
        chk("x_rdy", {e_rdy[u], f_rdy[u]}, xg);
        chk("dtr", dtr[u], rd);
        chk("err_ok", err[u], 0);
        break;
      end else if (k == 3) begin
        m_dtr[u] = $urandom;
        #1;
        timed_out = 1'b1;
        chk("x_rdy_to", {e_rdy[u], f_rdy[u]}, xg);
        chk("err_to", err[u], 1);
        chk("dtr_to", dtr[u], 0);
        break;
      end else begin
        m_dtr[u] = $urandom;
        #1;
        chk("x_rdy_wait", {e_rdy[u], f_rdy[u]}, 0);
        chk("err_wait", err[u], 0);
        chk("dtr_wait", dtr[u], 0);
        tick();
      end
    end

    tick();
    if (!timed_out) last_m[u] = ew;
    m_rdy[u] = spur;
    m_dtr[u] = $urandom;
    if (ew) begin
      if (!hold) e_req[u] = 1'b0;
    end else begin
      f_req[u] = 1'b0;
    end
    #1;
    chk("m_req_done", m_req[u], 0);
    chk("grant_done", grant[u], xg);
    chk("x_rdy_done", {e_rdy[u], f_rdy[u]}, 0);
    chk("err_done", err[u], 0);
    chk("dtr_done", dtr[u], 0);

    tick();
    m_rdy[u] = 1'b0;
    if (ew && hold) e_req[u] = 1'b0;
    chk("grant_idle", grant[u], 0);
    chk("m_req_idle", m_req[u], 0);
    $display("txn dut%0d %s addr=%08h rw=%0d wait=%0d %s", u, ew ? "exec " : "fetch",
             xa, xrw, wt, timed_out ? "timeout" : "ok");
  endtask

  task automatic raise_e(input int u, input logic [31:0] a, input logic [31:0] d, input bit rw);
    e_req[u] = 1'b1; e_addr[u] = a; e_dtw[u] = d; e_rw[u] = rw;
  endtask

  task automatic raise_f(input int u, input logic [31:0] a);
    f_req[u] = 1'b1; f_addr[u] = a;
  endtask

  initial begin
    reset = 1'b1;
    f_req = '0; e_req = '0; e_rw = '0; m_rdy = '0;
    f_addr = '0; e_addr = '0; e_dtw = '0; m_dtr = '0;
    last_m[0] = 1'b0; last_m[1] = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    for (int u = 0; u < 2; u++) begin
      chk("rst_m_req", m_req[u], 0);
      chk("rst_grant", grant[u], 0);
      chk("rst_m_addr", m_addr[u], 0);
      chk("rst_m_dtw", m_dtw[u], 0);
      chk("rst_m_rw", m_rw[u], 0);
      chk("rst_err", err[u], 0);
      chk("rst_rdy", {e_rdy[u], f_rdy[u]}, 0);
      chk("rst_dtr", dtr[u], 0);
    end
    tick();
    chk("idle_stays", m_req[0], 0);

    // Round-robin with both requests held: execute, fetch, execute, fetch.
    for (int i = 0; i < 4; i++) begin
      if (!e_req[1]) raise_e(1, $urandom, $urandom, 1'($urandom));
      if (!f_req[1]) raise_f(1, $urandom);
      chk("rr_order", {e_req[1] && !(f_req[1] && last_m[1])}, (i % 2 == 0) ? 1 : 0);
      serve(1, 0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    end
    f_req[1] = 1'b0; e_req[1] = 1'b0;
    tick();

    // Single execute write, ack on the third BUSY cycle.
    raise_e(0, 32'h100, 32'hDEADBEEF, 1'b1);
    serve(0, 2, 1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    // Fetch read with zero-wait memory.
    raise_f(0, 32'h40);
    serve(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678);
    // Fixed priority, both held: fetch starves while execute keeps requesting.
    for (int i = 0; i < 3; i++) begin
      if (!e_req[0]) raise_e(0, $urandom, $urandom, 1'($urandom));
      if (!f_req[0]) raise_f(0, $urandom);
      serve(0, 1, 1'b1, 1'b0, 1'b0, 1'b1, $urandom);
      chk("fetch_starved", f_req[0], 1);
    end
    serve(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    // Watchdog abort with the memory silent.
    raise_e(0, 32'h200, 32'h55AA55AA, 1'b0);
    serve(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // Execute unit holding its request one cycle past e_rdy.
    raise_e(0, 32'h300, 32'hCAFEF00D, 1'b1);
    serve(0, 1, 1'b1, 1'b1, 1'b0, 1'b0, $urandom);
    // Requester dropping out mid-transaction still gets it completed.
    raise_f(0, 32'h500);
    serve(0, 2, 1'b1, 1'b0, 1'b1, 1'b0, $urandom);

    // Reset in the middle of a BUSY transaction.
    raise_e(0, 32'h400, 32'h01020304, 1'b1);
    tick();
    chk("pre_rst_m_req", m_req[0], 1);
    reset = 1'b1;
    tick();
    chk("midrst_m_req", m_req[0], 0);
    chk("midrst_grant", grant[0], 0);
    chk("midrst_m_addr", m_addr[0], 0);
    reset = 1'b0;
    last_m[0] = 1'b0; last_m[1] = 1'b0;
    e_req[0] = 1'b0;
    m_rdy[0] = 1'b1;
    m_dtr[0] = 32'hFFFF0000;
    #1;
    chk("late_ack_rdy", {e_rdy[0], f_rdy[0]}, 0);
    chk("late_ack_dtr", dtr[0], 0);
    tick();
    chk("late_ack_idle", m_req[0], 0);
    m_rdy[0] = 1'b0;

    // Randomized traffic on both instances.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 30; i++) begin
        bit h, d;
        if (!e_req[u] && ($urandom % 2 == 0)) raise_e(u, $urandom, $urandom, 1'($urandom));
        if (!f_req[u] && ($urandom % 2 == 0)) raise_f(u, $urandom);
        if (!e_req[u] && !f_req[u]) raise_f(u, $urandom);
        h = ($urandom % 3 == 0);
        d = !h && ($urandom % 4 == 0);
        serve(u, int'($urandom % 4), ($urandom % 5 != 0), h, d, 1'($urandom), $urandom);
      end
      f_req[u] = 1'b0; e_req[u] = 1'b0;
      tick();
      chk("final_idle", m_req[u], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
